// File: rtl/uart_receive_if.sv
// Receive-side handshake bundle for uart_receive: byte/valid/ack plus status pulses.
// master = receiver (drives data and status), slave = consumer (drives ack).
interface uart_receive_if;
   logic [7:0] data;
   logic       valid;
   logic       ack;
   logic       busy;
   logic       frame_error;
   logic       overrun;
   logic       parity_error;

   modport master (
      output data, valid, busy, frame_error, overrun, parity_error,
      input  ack
   );

   modport slave (
      input  data, valid, busy, frame_error, overrun, parity_error,
      output ack
   );
endinterface

// File: rtl/uart_receive.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, hold register with valid/ack handshake.
// Define UART_RX_PARITY_EN for 8E1 frames with a PARITY state and parity_error reporting.
module uart_receive #(
   parameter logic [31:0] CLKS_PER_BIT = 32'h28B0
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          UART_RX,
   uart_receive_if.master rx_if
);

   localparam logic [31:0] HALF     = CLKS_PER_BIT / 32'd2;
   localparam logic [31:0] HALF_END = HALF - 32'd1;
   localparam logic [31:0] BIT_END  = CLKS_PER_BIT - 32'd1;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        frame_error_q, frame_error_d;
   logic        overrun_q, overrun_d;
   logic        rx_meta_q, rx_s_q;
   logic        parity_bad;

`ifdef UART_RX_PARITY_EN
   logic parity_bad_q, parity_bad_d;
   logic parity_error_q, parity_error_d;
   assign parity_bad = parity_bad_q;
`else
   assign parity_bad = 1'b0;
`endif

   // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= UART_RX;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + 32'd1;
      idx_d         = idx_q;
      shift_d       = shift_q;
      data_d        = data_q;
      valid_d       = valid_q;
      frame_error_d = 1'b0;
      overrun_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_d   = parity_bad_q;
      parity_error_d = 1'b0;
`endif

      if (rx_if.ack && valid_q) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = 32'd0;
            if (!rx_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d   = 32'd0;
               idx_d   = 3'd0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d          = 32'd0;
               shift_d[idx_q] = rx_s_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (cnt_q == BIT_END) begin
               cnt_d          = 32'd0;
               parity_bad_d   = (rx_s_q != ^shift_q);
               parity_error_d = parity_bad_d;
               state_d        = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = 32'd0;
               if (rx_s_q) begin
                  state_d = S_IDLE;
                  // A commit beats a same-cycle ack: valid stays set and no overrun is flagged.
                  if (!parity_bad) begin
                     data_d    = shift_q;
                     valid_d   = 1'b1;
                     overrun_d = valid_q && !rx_if.ack;
                  end
               end else begin
                  state_d       = S_BREAK;
                  frame_error_d = !parity_bad;
               end
            end
         end
         S_BREAK: begin
            cnt_d = 32'd0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = 32'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         cnt_q         <= 32'd0;
         idx_q         <= 3'd0;
         shift_q       <= 8'h00;
         data_q        <= 8'h00;
         valid_q       <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shift_q       <= shift_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         frame_error_q <= frame_error_d;
         overrun_q     <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         parity_bad_q   <= 1'b0;
         parity_error_q <= 1'b0;
      end else begin
         parity_bad_q   <= parity_bad_d;
         parity_error_q <= parity_error_d;
      end
   end
   assign rx_if.parity_error = parity_error_q;
`else
   assign rx_if.parity_error = 1'b0;
`endif

   assign rx_if.data        = data_q;
   assign rx_if.valid       = valid_q;
   assign rx_if.busy        = (state_q != S_IDLE);
   assign rx_if.frame_error = frame_error_q;
   assign rx_if.overrun     = overrun_q;

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- UART receiver (8N1, LSB first). Counterpart of the existing `send` transmitter; same bit-period parameter convention.
- Samples PHYSICAL_UART_RX on PHYSICAL_CLOCK and delivers received bytes through a hold register with a valid/ack handshake.
- Reports framing and overrun events to the top level.

Parameters:
- CLKS_PER_BIT, 32'h28B0, CLK cycles per bit (10416 = 9600 baud at 100 MHz); must be >= 4.

Ports:
- CLK  in  1  system clock (PHYSICAL_CLOCK)
- RESET  in  1  synchronous, active-high reset
- UART_RX  in  1  asynchronous serial line, idle high
- data  out  8  last accepted byte
- valid  out  1  data holds an unacknowledged byte (level)
- ack  in  1  consumer takes data; clears valid
- busy  out  1  a frame is in progress (state != IDLE)
- frame_error  out  1  one-cycle pulse, stop bit sampled low
- overrun  out  1  one-cycle pulse, byte completed while valid was already high
- parity_error  out  1  one-cycle pulse, parity mismatch (constant 0 without macro)

Behaviour:
- Reset: every register cleared except the synchronizer. state=IDLE, data=8'h00, valid=0, busy=0, all pulses 0, cnt=0, bit index=0. Synchronizer flops reset to 1 (idle line).
- UART_RX passes through a 2-FF synchronizer; rx_s is the second flop. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2, integer division. cnt is 32 bits and is cleared on every state change.
- IDLE: on rx_s==0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt==HALF-1, sample rx_s:
  - 0: go to DATA, bit index=0.
  - 1: glitch; return to IDLE with no output.
- DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into shift bit [index] (LSB first), then cnt=0. After index 7, go to STOP (or PARITY, see Optional Feature).
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s:
  - 1: commit. data<=shift; valid<=1; if valid was already 1 and ack is low that cycle, pulse overrun (new byte still overwrites data). Go to IDLE.
  - 0: pulse frame_error, discard the byte, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. Prevents a held-low line from retriggering a start.
- Sampling points are therefore mid-bit: start at HALF cycles after detection, each later bit CLKS_PER_BIT cycles apart. valid rises the cycle after the mid-stop sample.
- Handshake:
  - ack while valid=1 clears valid next cycle.
  - ack while valid=0 is ignored.
  - Commit and ack in the same cycle: the commit wins (valid stays 1, new data), no overrun.
- Pulses (frame_error, overrun, parity_error) are high exactly one CLK cycle.
- busy is high in START/DATA/PARITY/STOP/BREAK.
- RESET mid-frame aborts immediately to IDLE. No pulse, and data is cleared.
- After STOP, the next falling edge may begin at once; back-to-back frames with no idle gap must be received.

Optional Feature:
- UART_RX_PARITY_EN
  - Defined: the frame is 8E1. After DATA the block enters PARITY and samples at cnt==CLKS_PER_BIT-1. If the sample != ^shift, parity_error pulses in that cycle and the byte is discarded (no commit, valid unchanged); the STOP state is still traversed for framing. If parity is correct, go to STOP as normal. If both parity and stop fail, only parity_error pulses, then BREAK.
  - Undefined: frame is 8N1, there is no PARITY state, and parity_error is tied 0.

Test Plan (CLKS_PER_BIT=16 in bench):
- 8N1 frame 0xA5, ideal timing: data=8'hA5 and valid=1 about 9.5 bit periods (~152 cycles) after the start edge; ack for 1 cycle; valid=0 next cycle; no pulses.
- 6-cycle low glitch while idle: returns to IDLE, busy drops by cycle 8 after the glitch, valid stays 0, no pulses.
- Frame 0x3C with stop bit forced low, line held low 40 cycles then high: frame_error pulses once, valid=0, busy high until the line returns high, then the next 0x81 frame is received correctly.
- Two back-to-back frames 0x11, 0x22 with no ack: after the second, data=8'h22, valid=1, overrun pulsed once. Repeat with ack asserted exactly on the second commit cycle: valid=1, no overrun.
- RESET asserted for 1 cycle midway through data bit 4 of 0xFF: state=IDLE, data=0, valid=0. A following 0x5A frame is received correctly.
- With UART_RX_PARITY_EN, 0x07 sent with parity bit 1 (correct): valid=1, data=8'h07. Same frame with parity 0: parity_error pulses, valid stays 0.
